// File: rtl/pwm_capture.sv
// pwm_capture: measures high time of three PWM phases over windows of max(periodTop,2) cycles.
// Latency: result valid L+1 edges after enable is sampled high, then one result every L cycles.
// Backpressure: valid/ready; an unaccepted result causes the new one to be dropped and flags overrun.
module pwm_capture #(
  parameter int D_WIDTH = 19
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic [D_WIDTH-1:0] periodTop,
  input  logic               pwmA_in,
  input  logic               pwmB_in,
  input  logic               pwmC_in,
  output logic [D_WIDTH-1:0] dutyA_out,
  output logic [D_WIDTH-1:0] dutyB_out,
  output logic [D_WIDTH-1:0] dutyC_out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic               overrun_out,
  output logic               multi_out,
  input  logic               clear_in
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic                    state;
  // First RUN cycle after IDLE only primes the pipeline: the pin sampled on the
  // enabling edge belongs to no window, so the first window starts one cycle later.
  logic                    prime;
  logic [2:0]              pwm_q;
  logic [2:0]              pwm_prev;
  logic [D_WIDTH-1:0]      len;
  logic [D_WIDTH-1:0]      win_cnt;
  logic [2:0][D_WIDTH-1:0] hi;
  logic [2:0][1:0]         edges;

  logic [2:0]              rise;
  logic [2:0][D_WIDTH-1:0] hi_fin;
  logic [2:0][1:0]         edge_fin;
  logic                    multi_hit;
  logic                    counting;
  logic                    win_end;
  logic                    accept;
  logic [D_WIDTH-1:0]      len_next;

  // Per-cycle window arithmetic: final counts including the current sample, saturating edge counts.
  always_comb begin
    rise      = pwm_q & ~pwm_prev;
    multi_hit = 1'b0;
    hi_fin    = '0;
    edge_fin  = '0;
    for (int i = 0; i < 3; i++) begin
      hi_fin[i]   = hi[i] + D_WIDTH'(pwm_q[i]);
      edge_fin[i] = (rise[i] && edges[i] != 2'd2) ? edges[i] + 2'd1 : edges[i];
      multi_hit   = multi_hit | edge_fin[i][1];
    end
    len_next = (periodTop < D_WIDTH'(2)) ? D_WIDTH'(2) : periodTop;
    counting = (state == RUN) && enable && !prime;
    win_end  = counting && (win_cnt == len - D_WIDTH'(1));
    accept   = win_end && (!valid_out || ready_in);
  end

  // Input register plus one-cycle history for rising-edge detection (kept across windows).
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      pwm_q    <= '0;
      pwm_prev <= '0;
    end else begin
      pwm_q    <= {pwmC_in, pwmB_in, pwmA_in};
      pwm_prev <= pwm_q;
    end
  end

  // FSM and window counters; a new window starts right after each window end.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state   <= IDLE;
      prime   <= 1'b0;
      len     <= D_WIDTH'(2);
      win_cnt <= '0;
      hi      <= '0;
      edges   <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      prime   <= 1'b0;
      win_cnt <= '0;
      hi      <= '0;
      edges   <= '0;
    end else if (state == IDLE) begin
      state   <= RUN;
      prime   <= 1'b1;
      len     <= len_next;
      win_cnt <= '0;
      hi      <= '0;
      edges   <= '0;
    end else if (prime) begin
      prime <= 1'b0;
    end else if (win_end) begin
      len     <= len_next;
      win_cnt <= '0;
      hi      <= '0;
      edges   <= '0;
    end else begin
      win_cnt <= win_cnt + D_WIDTH'(1);
      hi      <= hi_fin;
      edges   <= edge_fin;
    end
  end

  // Result registers and handshake; a pending result is never overwritten.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      dutyA_out <= '0;
      dutyB_out <= '0;
      dutyC_out <= '0;
      valid_out <= 1'b0;
    end else if (accept) begin
      dutyA_out <= hi_fin[0];
      dutyB_out <= hi_fin[1];
      dutyC_out <= hi_fin[2];
      valid_out <= 1'b1;
    end else if (valid_out && ready_in) begin
      valid_out <= 1'b0;
    end
  end

  // Sticky status flags; a set on the same edge as a clear takes priority.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      overrun_out <= 1'b0;
      multi_out   <= 1'b0;
    end else begin
      overrun_out <= (win_end && !accept) | (overrun_out & ~clear_in);
      multi_out   <= (win_end && multi_hit) | (multi_out & ~clear_in);
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: drives per-window pulse patterns, queues the
// expected duty words as each window is driven and compares them on every transfer.
module tb_pwm_capture;

  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rstb = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] periodTop = '0;
  logic          pwmA_in = 1'b0;
  logic          pwmB_in = 1'b0;
  logic          pwmC_in = 1'b0;
  logic [DW-1:0] dutyA_out;
  logic [DW-1:0] dutyB_out;
  logic [DW-1:0] dutyC_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic          overrun_out;
  logic          multi_out;
  logic          clear_in = 1'b0;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } res_t;

  res_t q[$];
  res_t mon_e;
  int   total = 0;
  int   bad = 0;

  pwm_capture #(.D_WIDTH(DW)) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .periodTop(periodTop),
    .pwmA_in(pwmA_in), .pwmB_in(pwmB_in), .pwmC_in(pwmC_in),
    .dutyA_out(dutyA_out), .dutyB_out(dutyB_out), .dutyC_out(dutyC_out),
    .valid_out(valid_out), .ready_in(ready_in),
    .overrun_out(overrun_out), .multi_out(multi_out), .clear_in(clear_in)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every transfer seen before the edge pops one expected result.
  always @(negedge clk) begin
    if (!rstb && valid_out && ready_in) begin
      if (q.size() == 0) begin
        check_val("spurious_result", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check_val("dutyA", dutyA_out, mon_e.a);
        check_val("dutyB", dutyB_out, mon_e.b);
        check_val("dutyC", dutyC_out, mon_e.c);
      end
    end
  end

  function automatic logic hi_at(input int p, input int len, input bit two);
    return (p < len) || (two && p >= 2 * len && p < 3 * len);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n windows of length L; A high for a0 (window 0) / a1 (later windows) cycles
  // from window start (plus a second pulse if two), B high b cycles, C high c cycles.
  // keep: bitmask of windows whose result must appear. rmode 0: ready=1,
  // 1: ready=0, 2: ready=1 only on the edge that ends window 1.
  task automatic run(input int L, input int pt, input int n, input int a0, input int a1,
                     input int b, input int c, input bit two, input int keep, input int rmode);
    int   p;
    int   w;
    int   a;
    res_t r;
    periodTop = DW'(pt);
    pwmA_in = 1'b0; pwmB_in = 1'b0; pwmC_in = 1'b0;
    ready_in = (rmode == 0);
    enable = 1'b1;
    tick();
    for (int k = 0; k <= n * L; k++) begin
      p = k % L;
      w = k / L;
      a = (w == 0) ? a0 : a1;
      if (rmode == 0 && k >= 1)
        check_val("valid_pulse", valid_out, (k > L && (k - 1) % L == 0) ? 1 : 0);
      if (rmode == 1 && k == L + 1) begin
        check_val("ovr_first_valid", valid_out, 1);
        check_val("ovr_first_flag", overrun_out, 0);
        check_val("ovr_first_dutyA", dutyA_out, a0);
      end
      pwmA_in = hi_at(p, a, two);
      pwmB_in = hi_at(p, b, 1'b0);
      pwmC_in = hi_at(p, c, 1'b0);
      if (rmode == 2) ready_in = (k == 2 * L);
      if (p == L - 1 && w < n && keep[w]) begin
        r.a = DW'(two ? 2 * a : a);
        r.b = DW'(b);
        r.c = DW'(c);
        q.push_back(r);
      end
      tick();
    end
    enable = 1'b0;
    pwmA_in = 1'b0; pwmB_in = 1'b0; pwmC_in = 1'b0;
    if (rmode == 2) ready_in = 1'b0;
    tick();
  endtask

  task automatic drain();
    ready_in = 1'b1;
    for (int i = 0; i < 200 && q.size() > 0; i++) tick();
    tick();
    check_val("drain_empty", q.size(), 0);
    check_val("drain_valid_low", valid_out, 0);
  endtask

  task automatic clear_flags();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask

  initial begin
    int   nval;
    res_t r;
    #12;
    check_val("rst_dutyA", dutyA_out, 0);
    check_val("rst_dutyB", dutyB_out, 0);
    check_val("rst_dutyC", dutyC_out, 0);
    check_val("rst_valid", valid_out, 0);
    check_val("rst_overrun", overrun_out, 0);
    check_val("rst_multi", multi_out, 0);
    tick();
    rstb = 1'b0;
    tick();

    // Full-on pins: every window reads L.
    run(2048, 2048, 3, 2048, 2048, 2048, 2048, 1'b0, 7, 0);
    drain();
    check_val("ones_overrun", overrun_out, 0);
    check_val("ones_multi", multi_out, 0);

    // Single pulses per window.
    run(2048, 2048, 2, 1024, 1024, 512, 0, 1'b0, 3, 0);
    drain();
    check_val("pulse_multi", multi_out, 0);

    // Backpressure across two windows: second result dropped, overrun set.
    run(1000, 1000, 2, 300, 700, 0, 0, 1'b0, 1, 1);
    check_val("ovr_valid_held", valid_out, 1);
    check_val("ovr_dutyA_held", dutyA_out, 300);
    check_val("ovr_flag", overrun_out, 1);
    drain();
    check_val("ovr_sticky", overrun_out, 1);
    clear_flags();
    check_val("ovr_cleared", overrun_out, 0);

    // Ready on exactly the window-end edge: transfer and reload together.
    run(50, 50, 2, 10, 20, 5, 0, 1'b0, 3, 2);
    check_val("rdy_end_valid", valid_out, 1);
    check_val("rdy_end_dutyA", dutyA_out, 20);
    check_val("rdy_end_overrun", overrun_out, 0);
    drain();

    // Two pulses in one window.
    run(400, 400, 2, 100, 100, 0, 0, 1'b1, 3, 0);
    drain();
    check_val("two_pulse_multi", multi_out, 1);
    clear_flags();
    check_val("multi_cleared", multi_out, 0);

    // periodTop=0 clamps to 2-cycle windows.
    run(2, 0, 4, 2, 2, 1, 0, 1'b0, 15, 0);
    drain();
    check_val("short_multi", multi_out, 0);

    // Async reset mid-window while a result is pending.
    periodTop = DW'(20);
    pwmA_in = 1'b1;
    ready_in = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 25; k++) tick();
    check_val("pre_rst_valid", valid_out, 1);
    check_val("pre_rst_dutyA", dutyA_out, 20);
    #2;
    rstb = 1'b1;
    #1;
    check_val("arst_valid", valid_out, 0);
    check_val("arst_dutyA", dutyA_out, 0);
    tick();
    rstb = 1'b0;
    tick();  // now just after E0
    nval = 0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k < 21 && valid_out) nval++;
    end
    check_val("lat_early_valid", nval, 0);
    check_val("lat_valid", valid_out, 1);
    check_val("lat_dutyA", dutyA_out, 20);
    enable = 1'b0;
    pwmA_in = 1'b0;
    r.a = DW'(20); r.b = '0; r.c = '0;
    q.push_back(r);
    drain();

    // Enable dropped mid-window: partial window never reported.
    periodTop = DW'(30);
    pwmA_in = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    enable = 1'b0;
    nval = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (valid_out) nval++;
    end
    check_val("abort_no_result", nval, 0);
    check_val("final_queue", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the on-time of the three PWM phase outputs (A, B, C) of the FOC controller over fixed windows of `periodTop` clock cycles. At the end of each window it presents the three high-time counts as duty words, with a valid/ready handshake. It is the receiving end of the PWM generator: it turns the pins back into numbers, for closed-loop self-check in simulation and for on-chip duty monitoring. It sits beside `top` and consumes `pwmA_out`/`pwmB_out`/`pwmC_out` and the same `periodTop`.

## Interface
- `D_WIDTH`, default 19: width of `periodTop`, the duty words and the internal counters.

- `clk` in 1: clock.
- `rstb` in 1: reset, asynchronous, active-high.
- `enable` in 1: capture enable; low forces IDLE.
- `periodTop` in D_WIDTH: window length in cycles (unsigned); sampled at each window start.
- `pwmA_in`, `pwmB_in`, `pwmC_in` in 1: phase PWM pins, synchronous to `clk`.
- `dutyA_out`, `dutyB_out`, `dutyC_out` out D_WIDTH: high-cycle count of the last completed window.
- `valid_out` out 1: duty words valid.
- `ready_in` in 1: consumer accepts the duty words.
- `overrun_out` out 1: sticky; a window completed while the previous result was still unaccepted.
- `multi_out` out 1: sticky; some phase had more than one rising edge inside one window.
- `clear_in` in 1: synchronous clear of `overrun_out` and `multi_out`.

## Operation
- Pins are registered once into `pwmX_q`. All counting uses `pwmX_q`.
- Two-state FSM:
  - IDLE: window counter, high counters and edge counters all held at 0.
  - RUN: entered on the first edge where `enable`=1. Returns to IDLE on any edge where `enable`=0, discarding the partial window. Output registers and the flags are not touched when returning to IDLE.
- Window start:
  - Latch L = max(`periodTop`, 2).
  - Set `win_cnt`=0, `hiX`=0, `edgeX`=0.
- Each RUN cycle:
  - `hiX` += `pwmX_q`.
  - `edgeX` increments on the 0→1 transition of `pwmX_q`, saturating at 2. Edge detection uses the previous `pwmX_q`, which is also tracked across windows.
  - `win_cnt` += 1.
- Window end is the cycle with `win_cnt` == L-1:
  - Final count = `hiX` + `pwmX_q` for this cycle; the range is 0..L.
  - If `valid_out`=0, or `ready_in`=1 on the same edge: load `dutyX_out` with the final counts and set `valid_out`=1.
  - Otherwise: keep the old `dutyX_out`, drop the new result, and set `overrun_out`=1.
  - If any `edgeX` ≥ 2 (counting this cycle's edge): set `multi_out`=1.
  - The next window starts on the following cycle. There is no dead cycle.
- Handshake:
  - Transfer occurs on an edge with `valid_out`=1 and `ready_in`=1.
  - After a transfer, `valid_out` falls unless a new window ends on the same edge. In that case the new data loads and `valid_out` stays 1.
  - `dutyX_out` is stable while `valid_out`=1 and not transferred.
- Flags: `clear_in`=1 clears both flags on the next edge. If a set and a clear happen on the same edge, set wins.
- `periodTop` changes mid-window take effect at the next window start.

## Timing
- Reset values:
  - `dutyA_out`/`dutyB_out`/`dutyC_out` = 0.
  - `valid_out`=0, `overrun_out`=0, `multi_out`=0.
  - FSM in IDLE, `pwmX_q`=0.
- Reset is asynchronous and can occur mid-window. All state returns to the reset values immediately, and any pending result is lost.
- Window alignment: `enable` is sampled high at edge E0. Window 0 covers the pins as sampled at edges E0+1 … E0+L, because of the one-cycle input register.
- Latency: `valid_out` rises at edge E0+L+1, one edge after the last sample of the window is registered. Subsequent windows raise `valid_out` every L cycles.
- Counter widths: `win_cnt`, `hiX` and the duty words are D_WIDTH bits. L ≤ 2^D_WIDTH − 1, so the maximum count L fits and there is no overflow.

## Test plan
- `periodTop`=2048, all pins held at 1, `ready_in`=1 → every window gives duty A/B/C = 2048, `valid_out` pulses at a period of 2048, flags stay 0.
- `periodTop`=2048, A = one 1024-high pulse per window, B = 512, C held at 0 → duty words 1024/512/0, `multi_out`=0.
- `ready_in` held at 0 across two windows with A at 300 then 700 → `dutyA_out` stays 300 and `valid_out` stays 1. `overrun_out` sets at the end of the second window. Raising `ready_in` then transfers 300. `clear_in` then clears the flag.
- `ready_in` asserted exactly on a window-end edge with `valid_out`=1 → new data loads, `valid_out` stays 1, `overrun_out`=0.
- A given two 100-cycle pulses in one window → `dutyA_out`=200 and `multi_out`=1. `periodTop`=0 → windows of 2 cycles.
- `rstb` pulse mid-window while `valid_out`=1 → all outputs return to 0 immediately. After release, the first result appears L+1 edges after `enable` is sampled high. `enable` dropped mid-window → no result is produced for the partial window.
